// File: rtl/axicb_pkg.sv
// Shared types and width helpers for the crossbar completion path.
package axicb_pkg;

  localparam int AXI_ID_W_DEF = 8;
  localparam int MST_NB_DEF   = 4;
  localparam int OSTD_DEF     = 4;
  localparam int CNT_W        = 8;
  localparam int RANK_W       = $clog2(OSTD_DEF) + 1;

  function automatic int rank_w(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef struct packed {
    logic                    vld;
    logic [AXI_ID_W_DEF-1:0] id;
    logic [MST_NB_DEF-1:0]   mst;
    logic [CNT_W-1:0]        len;
    logic [RANK_W-1:0]       rank;
    logic [CNT_W-1:0]        cnt;
  } cpl_entry_t;

endpackage

// File: rtl/axicb_cpl_router_if.sv
// Request/completion bundle between a slave port and the completion switch.
interface axicb_cpl_router_if #(
  parameter int AXI_ID_W = 8,
  parameter int MST_NB   = 4
);
  logic                a_valid;
  logic                a_ready;
  logic [AXI_ID_W-1:0] a_id;
  logic [7:0]          a_len;
  logic [MST_NB-1:0]   a_mst;
  logic                c_valid;
  logic                c_ready;
  logic [AXI_ID_W-1:0] c_id;
  logic                c_last;
  logic [MST_NB-1:0]   m_valid;
  logic [MST_NB-1:0]   m_ready;
  logic [MST_NB-1:0]   c_mst;
  logic                unmatched;
  logic                len_err;
  logic                busy;

  modport slave (
    input  a_valid, a_id, a_len, a_mst,
    input  c_valid, c_id, c_last, m_ready,
    output a_ready, c_ready, m_valid, c_mst,
    output unmatched, len_err, busy
  );

  modport master (
    output a_valid, a_id, a_len, a_mst,
    output c_valid, c_id, c_last, m_ready,
    input  a_ready, c_ready, m_valid, c_mst,
    input  unmatched, len_err, busy
  );
endinterface

// File: rtl/axicb_cpl_slot.sv
// One outstanding-request entry: match, same-ID rank ageing, release.
// Beat counting only exists when AXICB_CPL_LEN_CHECK_EN is defined.
module axicb_cpl_slot
  import axicb_pkg::*;
#(
  parameter int RD_PATH = 0,
  parameter int ID_W    = 8,
  parameter int MST_W   = 4,
  parameter int RW      = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             alloc,
  input  logic [ID_W-1:0]  a_id,
  input  logic [CNT_W-1:0] a_len,
  input  logic [MST_W-1:0] a_mst,
  input  logic [RW-1:0]    a_rank,
  input  logic             c_hs,
  input  logic             rel_any,
  input  logic [ID_W-1:0]  c_id,
  input  logic             c_last,
  output logic             vld,
  output logic             match,
  output logic             rel,
  output logic             a_hit,
  output logic [MST_W-1:0] mst,
  output logic             err
);

  logic             vld_q, vld_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [MST_W-1:0] mst_q, mst_d;
  logic [RW-1:0]    rank_q, rank_d;
  logic             fire;

  assign vld   = vld_q;
  assign mst   = mst_q;
  assign match = vld_q && (id_q == c_id)
              && (rank_q == '0);
  assign fire  = match && c_hs;
  assign rel   = fire
              && ((RD_PATH == 0) || c_last);
  assign a_hit = vld_q && !rel
              && (id_q == a_id);

  always_comb begin
    vld_d  = vld_q;
    id_d   = id_q;
    mst_d  = mst_q;
    rank_d = rank_q;
    if (rel) begin
      vld_d = 1'b0;
    end else if (rel_any && vld_q
              && (id_q == c_id)
              && (rank_q != '0)) begin
      rank_d = rank_q - RW'(1);
    end
    if (alloc) begin
      vld_d  = 1'b1;
      id_d   = a_id;
      mst_d  = a_mst;
      rank_d = a_rank;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      vld_q  <= 1'b0;
      id_q   <= '0;
      mst_q  <= '0;
      rank_q <= '0;
    end else begin
      vld_q  <= vld_d;
      id_q   <= id_d;
      mst_q  <= mst_d;
      rank_q <= rank_d;
    end
  end

`ifdef AXICB_CPL_LEN_CHECK_EN
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    if (fire && !c_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (alloc) begin
      len_d = a_len;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  // last beat must land exactly on len; a non-last beat must not
  assign err = (RD_PATH != 0) && fire
            && (c_last ? (cnt_q != len_q)
                       : (cnt_q == len_q));
`else
  logic unused_len;
  assign unused_len = ^a_len;
  assign err = 1'b0;
`endif

endmodule

// File: rtl/axicb_cpl_router.sv
// Slave-side completion router: same-ID ordered return steering.
// Optional beat-count check: AXICB_CPL_LEN_CHECK_EN.
module axicb_cpl_router
  import axicb_pkg::*;
#(
  parameter int RD_PATH         = 0,
  parameter int AXI_ID_W        = 8,
  parameter int MST_NB          = 4,
  parameter int SLV_OSTDREQ_NUM = 4
) (
  input logic                aclk,
  input logic                srst,
  axicb_cpl_router_if.slave  bus
);

  localparam int N  = SLV_OSTDREQ_NUM;
  localparam int RW = rank_w(N);

  logic [N-1:0]             vld, match, rel;
  logic [N-1:0]             a_hit, alloc, err;
  logic [N-1:0][MST_NB-1:0] mst;
  logic [RW-1:0]            a_rank;
  logic [MST_NB-1:0]        c_mst;
  logic                     a_hs, found;
  logic                     matched, c_hs;
  logic                     rel_any;

  assign bus.a_ready = !(&vld);
  assign a_hs        = bus.a_valid && bus.a_ready;

  always_comb begin
    alloc  = '0;
    found  = 1'b0;
    a_rank = '0;
    for (int i = 0; i < N; i++) begin
      if (a_hs && !vld[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
      if (a_hit[i]) begin
        a_rank = a_rank + RW'(1);
      end
    end
  end

  always_comb begin
    c_mst = '0;
    for (int i = 0; i < N; i++) begin
      c_mst = c_mst
            | (mst[i] & {MST_NB{match[i]}});
    end
  end

  // unmatched completions are drained
  assign matched       = |match;
  assign bus.c_ready   = matched
                       ? |(bus.m_ready & c_mst)
                       : 1'b1;
  assign c_hs          = bus.c_valid && bus.c_ready;
  assign rel_any       = |rel;
  assign bus.c_mst     = c_mst;
  assign bus.m_valid   = c_mst
                       & {MST_NB{bus.c_valid}};
  assign bus.unmatched = bus.c_valid && !matched;
  assign bus.busy      = |vld;

  for (genvar g = 0; g < N; g++) begin : g_slot
    axicb_cpl_slot #(
      .RD_PATH (RD_PATH),
      .ID_W    (AXI_ID_W),
      .MST_W   (MST_NB),
      .RW      (RW)
    ) u_slot (
      .clk     (aclk),
      .srst    (srst),
      .alloc   (alloc[g]),
      .a_id    (bus.a_id),
      .a_len   (bus.a_len),
      .a_mst   (bus.a_mst),
      .a_rank  (a_rank),
      .c_hs    (c_hs),
      .rel_any (rel_any),
      .c_id    (bus.c_id),
      .c_last  (bus.c_last),
      .vld     (vld[g]),
      .match   (match[g]),
      .rel     (rel[g]),
      .a_hit   (a_hit[g]),
      .mst     (mst[g]),
      .err     (err[g])
    );
  end

`ifdef AXICB_CPL_LEN_CHECK_EN
  logic len_err_q, len_err_d;

  always_comb begin
    len_err_d = len_err_q | (|err);
  end

  always_ff @(posedge aclk) begin
    if (srst) len_err_q <= 1'b0;
    else      len_err_q <= len_err_d;
  end

  assign bus.len_err = len_err_q;
`else
  logic unused_err;
  assign unused_err  = ^err;
  assign bus.len_err = 1'b0;
`endif

endmodule

// File: tb/tb_axicb_cpl_router.sv
// Bench for axicb_cpl_router: read-path and write-path instances,
// vector tables checked through an expected-result queue.
module tb_axicb_cpl_router;

  localparam bit LC =
`ifdef AXICB_CPL_LEN_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    string    nm;
    bit       av;
    bit [7:0] aid;
    bit [7:0] alen;
    bit [3:0] amst;
    bit       cv;
    bit [7:0] cid;
    bit       cl;
    bit [3:0] mr;
    bit       rst;
    bit       ar;
    bit [3:0] mv;
    bit [3:0] cm;
    bit       cr;
    bit       um;
    bit       bz;
    bit       le;
  } vec_t;

  logic clk = 1'b0;
  logic rst_r, rst_w;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t exp_q[$];
  vec_t rv[$];
  vec_t wv[$];

  always #5 clk = ~clk;

  axicb_cpl_router_if #(.AXI_ID_W(8), .MST_NB(4)) rif ();
  axicb_cpl_router_if #(.AXI_ID_W(8), .MST_NB(4)) wif ();

  axicb_cpl_router #(
    .RD_PATH(1), .AXI_ID_W(8),
    .MST_NB(4), .SLV_OSTDREQ_NUM(4)
  ) u_rd (.aclk(clk), .srst(rst_r), .bus(rif));

  axicb_cpl_router #(
    .RD_PATH(0), .AXI_ID_W(8),
    .MST_NB(4), .SLV_OSTDREQ_NUM(4)
  ) u_wr (.aclk(clk), .srst(rst_w), .bus(wif));

  function automatic vec_t mk(
    string nm, bit av, int aid, int alen, int amst,
    bit cv, int cid, bit cl, int mr, bit rst,
    bit ar, int mv, int cm, bit cr, bit um,
    bit bz, bit le);
    vec_t v;
    v.nm = nm;   v.av = av;
    v.aid = 8'(aid);  v.alen = 8'(alen);
    v.amst = 4'(amst); v.cv = cv;
    v.cid = 8'(cid);  v.cl = cl;
    v.mr = 4'(mr);    v.rst = rst;
    v.ar = ar;   v.mv = 4'(mv);
    v.cm = 4'(cm); v.cr = cr;
    v.um = um;   v.bz = bz;  v.le = le;
    return v;
  endfunction

  function automatic vec_t idle(string nm, bit bz, bit le);
    return mk(nm, 0,0,0,0, 0,0,0,15, 0,
              1,0,0,1,0, bz, le);
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input bit wr);
    if (wr) begin
      rst_w = v.rst;
      wif.a_valid = v.av;  wif.a_id = v.aid;
      wif.a_len = v.alen;  wif.a_mst = v.amst;
      wif.c_valid = v.cv;  wif.c_id = v.cid;
      wif.c_last = v.cl;   wif.m_ready = v.mr;
    end else begin
      rst_r = v.rst;
      rif.a_valid = v.av;  rif.a_id = v.aid;
      rif.a_len = v.alen;  rif.a_mst = v.amst;
      rif.c_valid = v.cv;  rif.c_id = v.cid;
      rif.c_last = v.cl;   rif.m_ready = v.mr;
    end
  endtask

  task automatic compare(input vec_t e, input bit wr);
    logic       ar, cr, um, bz, le;
    logic [3:0] mv, cm;
    string      p;
    if (wr) begin
      ar = wif.a_ready; cr = wif.c_ready;
      um = wif.unmatched; bz = wif.busy;
      le = wif.len_err; mv = wif.m_valid;
      cm = wif.c_mst;
      p = {"wr.", e.nm};
    end else begin
      ar = rif.a_ready; cr = rif.c_ready;
      um = rif.unmatched; bz = rif.busy;
      le = rif.len_err; mv = rif.m_valid;
      cm = rif.c_mst;
      p = {"rd.", e.nm};
    end
    chk({p, ".a_ready"},   8'(ar), 8'(e.ar));
    chk({p, ".m_valid"},   8'(mv), 8'(e.mv));
    chk({p, ".c_mst"},     8'(cm), 8'(e.cm));
    chk({p, ".c_ready"},   8'(cr), 8'(e.cr));
    chk({p, ".unmatched"}, 8'(um), 8'(e.um));
    chk({p, ".busy"},      8'(bz), 8'(e.bz));
    chk({p, ".len_err"},   8'(le), 8'(e.le));
  endtask

  task automatic run(input vec_t v, input bit wr);
    vec_t e;
    drive(v, wr);
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    compare(e, wr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t rstv;
    rstv = mk("reset", 0,0,0,0, 0,0,0,15, 1,
              1,0,0,1,0,0,0);
    drive(rstv, 1'b0);
    drive(rstv, 1'b1);

    // read path: burst, unmatched, backpressure, ordering, fill
    rv.push_back(mk("a3",  1,3,2,2, 0,0,0,15,0, 1,0,0,1,0,0,0));
    rv.push_back(mk("b1",  0,0,0,0, 1,3,0,15,0, 1,2,2,1,0,1,0));
    rv.push_back(mk("b2",  0,0,0,0, 1,3,0,15,0, 1,2,2,1,0,1,0));
    rv.push_back(mk("b3",  0,0,0,0, 1,3,1,15,0, 1,2,2,1,0,1,0));
    rv.push_back(idle("idle0", 0, 0));
    rv.push_back(mk("a4",  1,4,0,8, 0,0,0,15,0, 1,0,0,1,0,0,0));
    rv.push_back(mk("um9", 0,0,0,0, 1,9,1,15,0, 1,0,0,1,1,1,0));
    rv.push_back(mk("c4",  0,0,0,0, 1,4,1,15,0, 1,8,8,1,0,1,0));
    rv.push_back(idle("idle1", 0, 0));
    rv.push_back(mk("a7",  1,7,0,4, 0,0,0,15,0, 1,0,0,1,0,0,0));
    for (int i = 0; i < 5; i++)
      rv.push_back(mk("bp", 0,0,0,0, 1,7,1,11,0, 1,4,4,0,0,1,0));
    rv.push_back(mk("c7",  0,0,0,0, 1,7,1,15,0, 1,4,4,1,0,1,0));
    rv.push_back(idle("idle2", 0, 0));
    rv.push_back(mk("ac6", 1,6,0,1, 1,6,1,15,0, 1,0,0,1,1,0,0));
    rv.push_back(mk("c6",  0,0,0,0, 1,6,1,15,0, 1,1,1,1,0,1,0));
    rv.push_back(idle("idle3", 0, 0));
    rv.push_back(mk("a5a", 1,5,0,1, 0,0,0,15,0, 1,0,0,1,0,0,0));
    rv.push_back(mk("a5b", 1,5,0,4, 0,0,0,15,0, 1,0,0,1,0,1,0));
    rv.push_back(mk("c5a", 0,0,0,0, 1,5,1,15,0, 1,1,1,1,0,1,0));
    rv.push_back(mk("c5b", 0,0,0,0, 1,5,1,15,0, 1,4,4,1,0,1,0));
    rv.push_back(idle("idle4", 0, 0));
    rv.push_back(mk("a2a", 1,2,0,1, 0,0,0,15,0, 1,0,0,1,0,0,0));
    rv.push_back(mk("a2b", 1,2,0,2, 0,0,0,15,0, 1,0,0,1,0,1,0));
    rv.push_back(mk("ac2", 1,2,0,4, 1,2,1,15,0, 1,1,1,1,0,1,0));
    rv.push_back(mk("c2b", 0,0,0,0, 1,2,1,15,0, 1,2,2,1,0,1,0));
    rv.push_back(mk("c2c", 0,0,0,0, 1,2,1,15,0, 1,4,4,1,0,1,0));
    rv.push_back(idle("idle5", 0, 0));
    rv.push_back(mk("f10", 1,10,0,1, 0,0,0,15,0, 1,0,0,1,0,0,0));
    rv.push_back(mk("f11", 1,11,0,2, 0,0,0,15,0, 1,0,0,1,0,1,0));
    rv.push_back(mk("f12", 1,12,0,4, 0,0,0,15,0, 1,0,0,1,0,1,0));
    rv.push_back(mk("f13", 1,13,0,8, 0,0,0,15,0, 1,0,0,1,0,1,0));
    rv.push_back(mk("cfull",0,0,0,0, 1,11,1,15,0, 0,2,2,1,0,1,0));
    rv.push_back(mk("a14", 1,14,0,2, 0,0,0,15,0, 1,0,0,1,0,1,0));
    rv.push_back(mk("a15x",1,15,0,4, 0,0,0,15,0, 0,0,0,1,0,1,0));
    rv.push_back(mk("c10", 0,0,0,0, 1,10,1,15,0, 0,1,1,1,0,1,0));
    rv.push_back(mk("c12", 0,0,0,0, 1,12,1,15,0, 1,4,4,1,0,1,0));
    rv.push_back(mk("c13", 0,0,0,0, 1,13,1,15,0, 1,8,8,1,0,1,0));
    rv.push_back(mk("c14", 0,0,0,0, 1,14,1,15,0, 1,2,2,1,0,1,0));
    rv.push_back(mk("um15",0,0,0,0, 1,15,1,15,0, 1,0,0,1,1,0,0));
    rv.push_back(mk("a1",  1,1,1,1, 0,0,0,15,0, 1,0,0,1,0,0,0));
    rv.push_back(mk("c1",  0,0,0,0, 1,1,1,15,0, 1,1,1,1,0,1,0));
    rv.push_back(idle("lerr0", 0, LC));
    rv.push_back(idle("lerr1", 0, LC));
    rv.push_back(mk("a8",  1,8,3,4, 0,0,0,15,0, 1,0,0,1,0,0,LC));
    rv.push_back(mk("b8",  0,0,0,0, 1,8,0,15,0, 1,4,4,1,0,1,LC));
    rv.push_back(mk("rst", 0,0,0,0, 0,8,0,15,1, 1,0,4,1,0,1,LC));
    rv.push_back(mk("post",0,0,0,0, 1,8,1,15,0, 1,0,0,1,1,0,0));

    // write path: one-beat release, c_last ignored
    wv.push_back(mk("a5a", 1,5,0,1, 0,0,0,15,0, 1,0,0,1,0,0,0));
    wv.push_back(mk("a5b", 1,5,0,4, 0,0,0,15,0, 1,0,0,1,0,1,0));
    wv.push_back(mk("c5a", 0,0,0,0, 1,5,0,15,0, 1,1,1,1,0,1,0));
    wv.push_back(mk("c5b", 0,0,0,0, 1,5,0,15,0, 1,4,4,1,0,1,0));
    wv.push_back(idle("idle0", 0, 0));
    wv.push_back(mk("a9",  1,9,0,2, 0,0,0,15,0, 1,0,0,1,0,0,0));
    wv.push_back(mk("bp9", 0,0,0,0, 1,9,0,13,0, 1,2,2,0,0,1,0));
    wv.push_back(mk("c9",  0,0,0,0, 1,9,0,15,0, 1,2,2,1,0,1,0));
    wv.push_back(idle("idle1", 0, 0));

    repeat (2) @(posedge clk);
    #1;
    run(rstv, 1'b0);
    run(rstv, 1'b1);
    foreach (rv[i]) run(rv[i], 1'b0);
    foreach (wv[i]) run(wv[i], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axicb_cpl_router.md
# axicb_cpl_router

Slave-side completion router for the crossbar. It records, for every address request accepted toward one slave, the originating master and burst length. It then steers the slave's completion stream (B or R) back to that master, using AXI same-ID ordering: the oldest outstanding request with a matching ID completes first. It is the return-path counterpart of the master-side per-ID completion tracker and sits between a slave interface and the completion switch.

## Interface
Parameters:
- RD_PATH, 0: 1 = read completions (multi-beat, release on last); 0 = write responses (one beat).
- AXI_ID_W, 8: ID width.
- MST_NB, 4: number of masters.
- SLV_OSTDREQ_NUM, 4: outstanding-request table depth (≥1).

Ports:
- aclk  in  1  clock
- srst  in  1  synchronous active-high reset
- a_valid  in  1  address request accepted toward slave
- a_ready  out  1  table has a free slot
- a_id  in  AXI_ID_W  request ID
- a_len  in  8  ALEN (ignored when RD_PATH=0)
- a_mst  in  MST_NB  one-hot originating master
- c_valid  in  1  completion valid from slave
- c_ready  out  1  completion accepted
- c_id  in  AXI_ID_W  completion ID
- c_last  in  1  RLAST (ignored when RD_PATH=0)
- m_valid  out  MST_NB  completion valid per master
- m_ready  in  MST_NB  completion ready per master
- c_mst  out  MST_NB  one-hot master selected for current completion
- unmatched  out  1  current completion has no matching entry
- len_err  out  1  sticky beat-count mismatch
- busy  out  1  any entry valid

## Operation
- Table: SLV_OSTDREQ_NUM entries, each holding {vld, id, mst, len, rank, cnt}.
- Allocation: on a_valid & a_ready, write the lowest-index free entry.
  - rank = number of valid entries with the same id, excluding any entry released in the same cycle.
  - cnt = 0.
- Match: entry with vld & id==c_id & rank==0. At most one can exist.
- Routing, matched case: c_mst = entry.mst; m_valid = c_mst & {MST_NB{c_valid}}; c_ready = |(m_ready & c_mst).
- Unmatched case: unmatched = c_valid; c_ready = 1 (completion is drained); m_valid = 0; c_mst = 0.
- Release, RD_PATH=1: a matched handshake with c_last clears vld. A matched handshake without c_last increments cnt.
- Release, RD_PATH=0: every matched handshake clears vld.
- On release, every other valid entry with the same id decrements rank by 1.
- Allocation and release with the same ID in the same cycle: the new entry's rank excludes the released entry. Surviving entries decrement normally.
- a_ready = !(&vld), evaluated on current state. A slot freed in a cycle is not reusable until the next cycle.
- busy = |vld.

## Timing
- Completion path is combinational, zero latency: c_valid → m_valid, and m_ready → c_ready.
- A newly allocated entry becomes matchable on the cycle after its a_valid/a_ready handshake. A completion arriving in the same cycle as the allocation is unmatched.
- Table updates are registered on aclk.
- Reset: srst clears all vld, rank, cnt and len_err.
  - After reset: a_ready=1, busy=0, m_valid=0, c_mst=0, unmatched=0, len_err=0.
  - Reset mid-burst drops all entries; any later completion is unmatched.
- cnt width is 8. It wraps modulo 256 and never exceeds len in legal traffic.

## Configuration
- AXICB_CPL_LEN_CHECK_EN defined, RD_PATH=1: len_err is set, and stays set until srst, in either case:
  - matched c_last handshake with cnt != len;
  - matched non-last handshake with cnt == len.
  - The entry is still released on c_last.
- AXICB_CPL_LEN_CHECK_EN undefined: len and cnt are not stored and len_err is tied 0. Release is unchanged.
- RD_PATH=0: len_err is tied 0 regardless of the macro.

## Structure
- Shared package axicb_pkg holds:
  - entry struct typedef (parameterised by widths via localparams);
  - rank width constant: $clog2(SLV_OSTDREQ_NUM)+1.
- One sub-module, axicb_cpl_slot, holds one entry's registers plus its match, rank-decrement and release logic. The top instantiates SLV_OSTDREQ_NUM slots plus the free-slot priority encoder and the output mux.

## Test plan
- RD_PATH=1: allocate id=3 len=2 from master 1, then send 3 beats (last on third) with m_ready=1 → m_valid=4'b0010 on each beat; busy=0 after the third beat; len_err=0.
- Allocate id=5 from master 0, then id=5 from master 2; send two write responses id=5 → first routed to master 0, second to master 2.
- Fill 4 entries → a_ready=0. Release one, then a_valid on the next cycle → accepted into the freed (lowest) slot.
- Completion id=9 with no matching entry → unmatched=1, c_ready=1, m_valid=0, table unchanged.
- Hold m_ready=0 for the selected master for 5 cycles → c_ready=0, entry kept; then m_ready=1 → single handshake, release.
- With AXICB_CPL_LEN_CHECK_EN: len=1 burst ending with c_last on beat 1 → len_err=1 until srst. Assert srst mid-burst → all outputs at reset values.
